// File: rtl/clk_en_pkg.sv
// Shared types and default parameters for the PLL-lock supervisor and
// clock-enable generator.
package clk_en_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RST_HOLD  = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int unsigned DEF_N_CH     = 4;
  localparam int unsigned DEF_DIV_W    = 8;
  localparam int unsigned DEF_LOCK_CYC = 1024;
  localparam int unsigned DEF_RST_CYC  = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable channel: pending/active divide registers, a period counter
// and the single-cycle enable decode.
module clk_en_div
  import clk_en_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o
);

  logic [DIV_W-1:0] pend_q, pend_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tc;

  assign tc = (cnt_q == act_q);

  // A new divide only takes effect at the terminal count, so the running
  // period is never cut short; a load on that same cycle is used directly.
  always_comb begin
    pend_d = load_i ? div_i : pend_q;
    act_d  = act_q;
    cnt_d  = '0;
    if (!run_i) begin
      if (load_i) act_d = div_i;
    end else if (tc) begin
      act_d = pend_d;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      act_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ce_o = run_i & tc;

endmodule

// File: rtl/clk_en_gen.sv
// PLL lock supervisor: synchronises and filters the lock flag, sequences a
// clean downstream reset and drives N_CH phase-aligned clock enables.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int unsigned N_CH     = DEF_N_CH,
  parameter int unsigned DIV_W    = DEF_DIV_W,
  parameter int unsigned LOCK_CYC = DEF_LOCK_CYC,
  parameter int unsigned RST_CYC  = DEF_RST_CYC
) (
  input  logic                  pll_clk,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic [N_CH*DIV_W-1:0] div_val,
  input  logic [N_CH-1:0]       div_load,
  input  logic                  clr_lost,
  output logic                  ready,
  output logic                  sys_rst_n,
  output logic [N_CH-1:0]       ce,
  output logic                  lock_lost
);

  localparam int unsigned LW = cnt_width(LOCK_CYC);
  localparam int unsigned RW = cnt_width(RST_CYC);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYC - 1);

  logic [1:0]    sync_q;
  logic          locked_s;
  state_e        state_q, state_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          lost_q, lost_d;
  logic          ready_q, sys_rst_q;
  logic          run;

  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], locked};
  end
  assign locked_s = sync_q[1];

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        lock_cnt_d = '0;
        rst_cnt_d  = '0;
        if (locked_s) state_d = FILTER;
      end
      FILTER: begin
        if (!locked_s) begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = RST_HOLD;
          lock_cnt_d = '0;
          rst_cnt_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      RST_HOLD: begin
        if (!locked_s) begin
          state_d   = WAIT_LOCK;
          rst_cnt_d = '0;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d   = RUN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      RUN: begin
        if (!locked_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Setting on a lock loss takes priority over a simultaneous clear.
  always_comb begin
    lost_d = lost_q;
    if (state_q == RUN && !locked_s) lost_d = 1'b1;
    else if (clr_lost)               lost_d = 1'b0;
  end

  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      rst_cnt_q  <= '0;
      lost_q     <= 1'b0;
      ready_q    <= 1'b0;
      sys_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      lost_q     <= lost_d;
      ready_q    <= (state_d == RUN);
      sys_rst_q  <= (state_d == RUN);
    end
  end

  assign run       = (state_q == RUN);
  assign ready     = ready_q;
  assign sys_rst_n = sys_rst_q;
  assign lock_lost = lost_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      clk_en_div #(
        .DIV_W(DIV_W)
      ) u_div (
        .clk_i (pll_clk),
        .rst_ni(rst_n),
        .run_i (run),
        .load_i(div_load[gi]),
        .div_i (div_val[gi*DIV_W +: DIV_W]),
        .ce_o  (ce[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_en_gen.sv
// Randomised self-checking bench for clk_en_gen against an event-level
// model: lock streak length decides the state, per-channel next-pulse times.
module tb_clk_en_gen;

  localparam int N_CH     = 4;
  localparam int DIV_W    = 8;
  localparam int LOCK_CYC = 16;
  localparam int RST_CYC  = 4;
  localparam int REL_LAT  = 2 + LOCK_CYC + RST_CYC;

  logic                  pll_clk = 1'b0;
  logic                  rst_n, locked, clr_lost;
  logic [N_CH*DIV_W-1:0] div_val;
  logic [N_CH-1:0]       div_load;
  logic                  ready, sys_rst_n, lock_lost;
  logic [N_CH-1:0]       ce;

  clk_en_gen #(
    .N_CH(N_CH), .DIV_W(DIV_W), .LOCK_CYC(LOCK_CYC), .RST_CYC(RST_CYC)
  ) dut (
    .pll_clk  (pll_clk),
    .rst_n    (rst_n),
    .locked   (locked),
    .div_val  (div_val),
    .div_load (div_load),
    .clr_lost (clr_lost),
    .ready    (ready),
    .sys_rst_n(sys_rst_n),
    .ce       (ce),
    .lock_lost(lock_lost)
  );

  always #5 pll_clk = ~pll_clk;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  // Reference model state
  int streak;
  bit run_m, lost_m, h0, h1;
  int rc;
  int pend[N_CH], act[N_CH], nxt[N_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    streak = 0; run_m = 0; lost_m = 0; h0 = 0; h1 = 0; rc = 0;
    for (int i = 0; i < N_CH; i++) begin
      pend[i] = 0; act[i] = 0; nxt[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit ls, was_run;
    int v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls = h1; h1 = h0; h0 = locked;
    was_run = run_m;
    for (int i = 0; i < N_CH; i++) begin
      v = int'(div_val[i*DIV_W +: DIV_W]);
      if (div_load[i]) pend[i] = v;
      if (!was_run) begin
        if (div_load[i]) act[i] = v;
      end else if (rc == nxt[i]) begin
        act[i] = pend[i];
        nxt[i] = rc + act[i] + 1;
      end
    end
    if (was_run) rc++;
    streak = ls ? ((streak < 1000) ? streak + 1 : streak) : 0;
    run_m  = (streak > LOCK_CYC + RST_CYC);
    if (was_run && !ls) lost_m = 1;
    else if (clr_lost)  lost_m = 0;
    if (run_m && !was_run) begin
      rc = 0;
      for (int i = 0; i < N_CH; i++) nxt[i] = act[i];
    end
  endtask

  function automatic logic [N_CH-1:0] exp_ce();
    logic [N_CH-1:0] m;
    m = '0;
    for (int i = 0; i < N_CH; i++) m[i] = run_m && (rc == nxt[i]);
    return m;
  endfunction

  task automatic compare();
    chk("ready", 32'(ready), 32'(run_m));
    chk("sys_rst_n", 32'(sys_rst_n), 32'(run_m));
    chk("ce", 32'(ce), 32'(exp_ce()));
    chk("lock_lost", 32'(lock_lost), 32'(lost_m));
  endtask

  task automatic cyc();
    @(posedge pll_clk);
    model_edge();
    cyc_no++;
    @(negedge pll_clk);
    compare();
  endtask

  task automatic wait_ready(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ready && n < 200);
    chk(tag, 32'(n - 1), 32'(exp_lat));
  endtask

  task automatic rand_loads(input int clr_odds);
    div_load = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        div_load[i] = 1'b1;
        div_val[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 12));
      end
    end
    clr_lost = ($urandom_range(0, clr_odds) == 0);
  endtask

  initial begin
    int n;
    int first[N_CH];

    rst_n = 0; locked = 0; clr_lost = 0; div_val = '0; div_load = '0;
    model_reset();
    repeat (3) cyc();
    rst_n = 1;
    cyc();

    // Preload 0,1,2,9 then acquire lock
    div_val = {8'd9, 8'd2, 8'd1, 8'd0};
    div_load = '1;
    cyc();
    div_load = '0;
    locked = 1;
    wait_ready("rel_lat", REL_LAT);
    $display("phase: first RUN reached at cycle %0d", cyc_no);

    for (int i = 0; i < N_CH; i++) first[i] = -1;
    for (int t = 0; t < 12; t++) begin
      if (t > 0) cyc();
      for (int i = 0; i < N_CH; i++) if (ce[i] && first[i] < 0) first[i] = t;
    end
    chk("first_ce0", 32'(first[0]), 0);
    chk("first_ce1", 32'(first[1]), 1);
    chk("first_ce2", 32'(first[2]), 2);
    chk("first_ce3", 32'(first[3]), 9);

    // Reload ch3 with 3 while its counter sits at 4
    n = 0;
    while (!ce[3] && n < 50) begin cyc(); n++; end
    repeat (5) cyc();
    div_val[3*DIV_W +: DIV_W] = 8'd3;
    div_load = 4'b1000;
    cyc();
    div_load = '0;
    n = 1;
    while (!ce[3] && n < 50) begin cyc(); n++; end
    chk("reload_gap1", 32'(n), 5);
    n = 0;
    do begin cyc(); n++; end while (!ce[3] && n < 50);
    chk("reload_gap2", 32'(n), 4);
    $display("phase: ch3 reload done at cycle %0d", cyc_no);

    // Random reprogramming while locked
    for (int k = 0; k < 300; k++) begin
      rand_loads(15);
      cyc();
    end
    div_load = '0; clr_lost = 0;

    // Lock loss with clr_lost on the very same edge
    locked = 0;
    cyc(); cyc();
    clr_lost = 1;
    cyc();
    clr_lost = 0;
    chk("lost_set_wins", 32'(lock_lost), 1);
    chk("ready_drop", 32'(ready), 0);
    chk("ce_drop", 32'(ce), 0);
    repeat (2) cyc();
    clr_lost = 1;
    cyc();
    clr_lost = 0;
    chk("lost_cleared", 32'(lock_lost), 0);
    $display("phase: lock loss handled at cycle %0d", cyc_no);

    // One-cycle glitch mid-FILTER restarts the filter
    locked = 1;
    repeat (8) cyc();
    locked = 0;
    cyc();
    locked = 1;
    wait_ready("glitch_lat", REL_LAT);
    chk("glitch_no_lost", 32'(lock_lost), 0);

    // Random lock toggling with random loads and clears
    for (int k = 0; k < 600; k++) begin
      if (locked) locked = ($urandom_range(0, 59) != 0);
      else        locked = ($urandom_range(0, 3) == 0);
      rand_loads(20);
      cyc();
    end
    div_load = '0; clr_lost = 0;
    $display("phase: random lock toggling done at cycle %0d", cyc_no);

    // Clean relock, then asynchronous reset mid-RUN
    locked = 0;
    repeat (4) cyc();
    locked = 1;
    wait_ready("relock_lat", REL_LAT);
    repeat (7) cyc();
    #2 rst_n = 0;
    #1;
    chk("async_ready", 32'(ready), 0);
    chk("async_sys_rst_n", 32'(sys_rst_n), 0);
    chk("async_ce", 32'(ce), 0);
    chk("async_lock_lost", 32'(lock_lost), 0);
    model_reset();
    repeat (3) cyc();
    rst_n = 1;
    wait_ready("post_rst_lat", REL_LAT);
    chk("zero_div_ce", 32'(ce), 32'({N_CH{1'b1}}));
    repeat (10) cyc();
    $display("phase: async reset recovery done at cycle %0d", cyc_no);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
